// File: rtl/mips_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_defs_pkg
// Description : Shared MIPS opcode/funct encodings, ALU op codes and ALU
//               source-select codes used by the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs_pkg;

  // Primary opcodes
  localparam logic [5:0] c_opc_rtype = 6'b000000;
  localparam logic [5:0] c_opc_andi  = 6'b001100;
  localparam logic [5:0] c_opc_ori   = 6'b001101;
  localparam logic [5:0] c_opc_xori  = 6'b001110;
  localparam logic [5:0] c_opc_lui   = 6'b001111;

  // R-type function codes
  localparam logic [5:0] c_fn_sll = 6'b000000;
  localparam logic [5:0] c_fn_srl = 6'b000010;
  localparam logic [5:0] c_fn_sra = 6'b000011;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_xor = 6'b100110;
  localparam logic [5:0] c_fn_nor = 6'b100111;

  // ALU operation codes
  localparam logic [7:0] c_alu_nop = 8'h00;
  localparam logic [7:0] c_alu_and = 8'h24;
  localparam logic [7:0] c_alu_or  = 8'h25;
  localparam logic [7:0] c_alu_xor = 8'h26;
  localparam logic [7:0] c_alu_nor = 8'h27;
  localparam logic [7:0] c_alu_sll = 8'h7C;
  localparam logic [7:0] c_alu_srl = 8'h02;
  localparam logic [7:0] c_alu_sra = 8'h03;

  // ALU source-select codes
  localparam logic [2:0] c_sel_none  = 3'b000;
  localparam logic [2:0] c_sel_logic = 3'b001;
  localparam logic [2:0] c_sel_shift = 3'b010;

endpackage
`default_nettype wire

// File: rtl/ins_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ins_decode_ctrl
// Description : Combinational MIPS instruction decoder. Produces read
//               enables/addresses, immediate operands for disabled reads,
//               ALU controls and destination information.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_decode_ctrl
  import mips_defs_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int ALUOP_W = 8
) (
  input  logic [31:0]        ins,
  output logic               rd1_en,
  output logic               rd2_en,
  output logic [RF_AW-1:0]   addr1,
  output logic [RF_AW-1:0]   addr2,
  output logic [DATA_W-1:0]  imm1,
  output logic [DATA_W-1:0]  imm2,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         alu_sel,
  output logic [RF_AW-1:0]   wr_addr,
  output logic               wr_en,
  output logic               ins_err
);

  logic [5:0]       w_opc;
  logic [5:0]       w_fn;
  logic [RF_AW-1:0] w_rs;
  logic [RF_AW-1:0] w_rt;
  logic [RF_AW-1:0] w_rd;
  logic             w_ilog;
  logic             w_lui;
  logic             w_rlog;
  logic             w_shift;

  assign w_opc = ins[31:26];
  assign w_fn  = ins[5:0];
  assign w_rs  = RF_AW'(ins[25:21]);
  assign w_rt  = RF_AW'(ins[20:16]);
  assign w_rd  = RF_AW'(ins[15:11]);

  // Classify the instruction and pick its ALU operation
  always_comb begin
    w_ilog  = 1'b0;
    w_lui   = 1'b0;
    w_rlog  = 1'b0;
    w_shift = 1'b0;
    ins_err = 1'b0;
    alu_op  = ALUOP_W'(c_alu_nop);
    case (w_opc)
      c_opc_andi: begin w_ilog = 1'b1; alu_op = ALUOP_W'(c_alu_and); end
      c_opc_ori:  begin w_ilog = 1'b1; alu_op = ALUOP_W'(c_alu_or);  end
      c_opc_xori: begin w_ilog = 1'b1; alu_op = ALUOP_W'(c_alu_xor); end
      c_opc_lui:  begin w_lui  = 1'b1; alu_op = ALUOP_W'(c_alu_or);  end
      c_opc_rtype: begin
        case (w_fn)
          c_fn_and: begin w_rlog  = 1'b1; alu_op = ALUOP_W'(c_alu_and); end
          c_fn_or:  begin w_rlog  = 1'b1; alu_op = ALUOP_W'(c_alu_or);  end
          c_fn_xor: begin w_rlog  = 1'b1; alu_op = ALUOP_W'(c_alu_xor); end
          c_fn_nor: begin w_rlog  = 1'b1; alu_op = ALUOP_W'(c_alu_nor); end
          c_fn_sll: begin w_shift = 1'b1; alu_op = ALUOP_W'(c_alu_sll); end
          c_fn_srl: begin w_shift = 1'b1; alu_op = ALUOP_W'(c_alu_srl); end
          c_fn_sra: begin w_shift = 1'b1; alu_op = ALUOP_W'(c_alu_sra); end
          default:  ins_err = 1'b1;
        endcase
      end
      default: ins_err = 1'b1;
    endcase
  end

  // Operand routing and destination per instruction class; unknown -> NOP
  always_comb begin
    rd1_en  = 1'b0;
    rd2_en  = 1'b0;
    addr1   = '0;
    addr2   = '0;
    imm1    = '0;
    imm2    = '0;
    alu_sel = c_sel_none;
    wr_addr = '0;
    wr_en   = 1'b0;
    if (w_ilog || w_lui) begin
      // LUI ignores rs: source 1 stays a constant zero
      rd1_en  = w_ilog;
      addr1   = w_ilog ? w_rs : '0;
      imm2    = w_lui ? DATA_W'({ins[15:0], 16'h0000}) : DATA_W'(ins[15:0]);
      alu_sel = c_sel_logic;
      wr_addr = w_rt;
      wr_en   = 1'b1;
    end
    if (w_rlog || w_shift) begin
      // Shifts take the shift amount in place of rs
      rd1_en  = w_rlog;
      addr1   = w_rlog ? w_rs : '0;
      imm1    = w_shift ? DATA_W'(ins[10:6]) : '0;
      rd2_en  = 1'b1;
      addr2   = w_rt;
      alu_sel = w_shift ? c_sel_shift : c_sel_logic;
      wr_addr = w_rd;
      wr_en   = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ins_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ins_decode_pipe
// Description : MIPS ID stage: decode, EX/MEM operand forwarding, load-use
//               hazard detection and the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_decode_pipe
  import mips_defs_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int ALUOP_W = 8,
  parameter int FWD_EN  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  pc,
  input  logic [31:0]        ins,
  output logic               rd1_en,
  output logic               rd2_en,
  output logic [RF_AW-1:0]   addr1,
  output logic [RF_AW-1:0]   addr2,
  input  logic [DATA_W-1:0]  rf_data1,
  input  logic [DATA_W-1:0]  rf_data2,
  input  logic               ex_wr_en,
  input  logic [RF_AW-1:0]   ex_wr_addr,
  input  logic [DATA_W-1:0]  ex_wr_data,
  input  logic               ex_is_load,
  input  logic               mem_wr_en,
  input  logic [RF_AW-1:0]   mem_wr_addr,
  input  logic [DATA_W-1:0]  mem_wr_data,
  input  logic               stall_in,
  input  logic               flush,
  output logic               stall_req,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_pc,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         alu_sel,
  output logic [DATA_W-1:0]  src_data1,
  output logic [DATA_W-1:0]  src_data2,
  output logic [RF_AW-1:0]   wr_addr,
  output logic               wr_en,
  output logic               ins_err
);

  localparam logic c_fwd_on = (FWD_EN != 0);

  logic               w_rd1_en, w_rd2_en;
  logic [RF_AW-1:0]   w_addr1, w_addr2;
  logic [DATA_W-1:0]  w_imm1, w_imm2;
  logic [ALUOP_W-1:0] w_alu_op;
  logic [2:0]         w_alu_sel;
  logic [RF_AW-1:0]   w_wr_addr;
  logic               w_wr_en, w_ins_err;
  logic               w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
  logic [DATA_W-1:0]  w_src1, w_src2;

  ins_decode_ctrl #(
    .DATA_W  (DATA_W),
    .RF_AW   (RF_AW),
    .ALUOP_W (ALUOP_W)
  ) u_ctrl (
    .ins     (ins),
    .rd1_en  (w_rd1_en),
    .rd2_en  (w_rd2_en),
    .addr1   (w_addr1),
    .addr2   (w_addr2),
    .imm1    (w_imm1),
    .imm2    (w_imm2),
    .alu_op  (w_alu_op),
    .alu_sel (w_alu_sel),
    .wr_addr (w_wr_addr),
    .wr_en   (w_wr_en),
    .ins_err (w_ins_err)
  );

  // Register-file read port, quiet while in reset
  assign rd1_en = w_rd1_en & ~reset;
  assign rd2_en = w_rd2_en & ~reset;
  assign addr1  = reset ? '0 : w_addr1;
  assign addr2  = reset ? '0 : w_addr2;

  // Forwarding hits; register 0 never forwards
  assign w_ex_hit1  = c_fwd_on && ex_wr_en  && (ex_wr_addr  == w_addr1) && (w_addr1 != '0);
  assign w_ex_hit2  = c_fwd_on && ex_wr_en  && (ex_wr_addr  == w_addr2) && (w_addr2 != '0);
  assign w_mem_hit1 = c_fwd_on && mem_wr_en && (mem_wr_addr == w_addr1) && (w_addr1 != '0);
  assign w_mem_hit2 = c_fwd_on && mem_wr_en && (mem_wr_addr == w_addr2) && (w_addr2 != '0);

  // Source operand select: immediate, zero register, EX, MEM, then RF
  always_comb begin
    w_src1 = rf_data1;
    if (!w_rd1_en)           w_src1 = w_imm1;
    else if (w_addr1 == '0)  w_src1 = '0;
    else if (w_ex_hit1)      w_src1 = ex_wr_data;
    else if (w_mem_hit1)     w_src1 = mem_wr_data;
    w_src2 = rf_data2;
    if (!w_rd2_en)           w_src2 = w_imm2;
    else if (w_addr2 == '0)  w_src2 = '0;
    else if (w_ex_hit2)      w_src2 = ex_wr_data;
    else if (w_mem_hit2)     w_src2 = mem_wr_data;
  end

  // Load-use hazard: a load in EX targets a register this instruction reads
  assign stall_req = ~reset && in_valid && ex_is_load && ex_wr_en && (ex_wr_addr != '0) &&
                     ((w_rd1_en && (w_addr1 == ex_wr_addr)) ||
                      (w_rd2_en && (w_addr2 == ex_wr_addr)));

  // ID/EX register: reset > flush > hold > bubble > capture
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall_in && (stall_req || !in_valid))) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      alu_op    <= '0;
      alu_sel   <= '0;
      src_data1 <= '0;
      src_data2 <= '0;
      wr_addr   <= '0;
      wr_en     <= 1'b0;
      ins_err   <= 1'b0;
    end else if (!stall_in) begin
      out_valid <= 1'b1;
      out_pc    <= pc;
      alu_op    <= w_alu_op;
      alu_sel   <= w_alu_sel;
      src_data1 <= w_src1;
      src_data2 <= w_src2;
      wr_addr   <= w_wr_addr;
      wr_en     <= w_wr_en;
      ins_err   <= w_ins_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ins_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ins_decode_pipe
// Description : Self-checking bench for ins_decode_pipe: directed scenarios
//               followed by randomized traffic against a table-driven model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_decode_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall_in, flush, stall_req;
  logic [31:0] pc, ins, rf_data1, rf_data2;
  logic        rd1_en, rd2_en;
  logic [4:0]  addr1, addr2;
  logic        ex_wr_en, ex_is_load, mem_wr_en;
  logic [4:0]  ex_wr_addr, mem_wr_addr;
  logic [31:0] ex_wr_data, mem_wr_data;
  logic        out_valid, wr_en, ins_err;
  logic [31:0] out_pc, src_data1, src_data2;
  logic [7:0]  alu_op;
  logic [2:0]  alu_sel;
  logic [4:0]  wr_addr;

  logic [31:0] regs [32];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign rf_data1 = regs[addr1];
  assign rf_data2 = regs[addr2];

  ins_decode_pipe #(.DATA_W(32), .RF_AW(5), .ALUOP_W(8), .FWD_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pc(pc), .ins(ins),
    .rd1_en(rd1_en), .rd2_en(rd2_en), .addr1(addr1), .addr2(addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .ex_is_load(ex_is_load), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .stall_in(stall_in), .flush(flush),
    .stall_req(stall_req), .out_valid(out_valid), .out_pc(out_pc),
    .alu_op(alu_op), .alu_sel(alu_sel), .src_data1(src_data1),
    .src_data2(src_data2), .wr_addr(wr_addr), .wr_en(wr_en), .ins_err(ins_err)
  );

  // Instruction table: {opcode, funct, alu_op, alu_sel, kind}
  // kind 0 = I-type logic, 1 = LUI, 2 = R-type logic, 3 = shift
  localparam logic [24:0] TBL [11] = '{
    {6'b001100, 6'b000000, 8'h24, 3'b001, 2'd0},
    {6'b001101, 6'b000000, 8'h25, 3'b001, 2'd0},
    {6'b001110, 6'b000000, 8'h26, 3'b001, 2'd0},
    {6'b001111, 6'b000000, 8'h25, 3'b001, 2'd1},
    {6'b000000, 6'b100100, 8'h24, 3'b001, 2'd2},
    {6'b000000, 6'b100101, 8'h25, 3'b001, 2'd2},
    {6'b000000, 6'b100110, 8'h26, 3'b001, 2'd2},
    {6'b000000, 6'b100111, 8'h27, 3'b001, 2'd2},
    {6'b000000, 6'b000000, 8'h7C, 3'b010, 2'd3},
    {6'b000000, 6'b000010, 8'h02, 3'b010, 2'd3},
    {6'b000000, 6'b000011, 8'h03, 3'b010, 2'd3}
  };

  typedef struct packed {
    logic        ok;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic        en1, en2;
    logic [4:0]  a1, a2, wa;
    logic [31:0] imm1, imm2;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] s1, s2;
    logic [4:0]  wa;
    logic        we, err;
  } idex_t;

  idex_t m;
  int    m_lvl;   // 2: all fields known, 1: operands/dest unspecified, 0: only valid/we

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t        d;
    logic [24:0] e;
    d = '0;
    for (int i = 0; i < 11; i++) begin
      e = TBL[i];
      if (e[24:19] == w[31:26] && (e[1:0] < 2'd2 || e[18:13] == w[5:0])) begin
        d.ok  = 1'b1;
        d.op  = e[12:5];
        d.sel = e[4:2];
        case (e[1:0])
          2'd0: begin d.en1 = 1'b1; d.a1 = w[25:21]; d.imm2 = {16'h0, w[15:0]}; d.wa = w[20:16]; end
          2'd1: begin d.imm2 = {w[15:0], 16'h0}; d.wa = w[20:16]; end
          2'd2: begin d.en1 = 1'b1; d.a1 = w[25:21]; d.en2 = 1'b1; d.a2 = w[20:16]; d.wa = w[15:11]; end
          default: begin d.imm1 = {27'h0, w[10:6]}; d.en2 = 1'b1; d.a2 = w[20:16]; d.wa = w[15:11]; end
        endcase
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] ref_src(input logic en, input logic [4:0] a, input logic [31:0] imm);
    if (!en) return imm;
    if (a == 5'd0) return 32'h0;
    if (ex_wr_en && ex_wr_addr == a) return ex_wr_data;
    if (mem_wr_en && mem_wr_addr == a) return mem_wr_data;
    return regs[a];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check combinational outputs, advance the model, check ID/EX
  task automatic step();
    dec_t d;
    logic e_stall;
    #1;
    d = ref_decode(ins);
    e_stall = !reset && in_valid && ex_is_load && ex_wr_en && ex_wr_addr != 5'd0 &&
              ((d.en1 && d.a1 == ex_wr_addr) || (d.en2 && d.a2 == ex_wr_addr));
    check("rd1_en", 64'(rd1_en), 64'(!reset && d.en1));
    check("rd2_en", 64'(rd2_en), 64'(!reset && d.en2));
    if (reset) begin
      check("addr1_rst", 64'(addr1), 64'd0);
      check("addr2_rst", 64'(addr2), 64'd0);
    end else begin
      if (d.en1) check("addr1", 64'(addr1), 64'(d.a1));
      if (d.en2) check("addr2", 64'(addr2), 64'(d.a2));
    end
    check("stall_req", 64'(stall_req), 64'(e_stall));

    if (reset) begin
      m = '0; m_lvl = 2;
    end else if (flush) begin
      m.valid = 1'b0; m.we = 1'b0; m_lvl = 0;
    end else if (stall_in) begin
      // hold
    end else if (e_stall || !in_valid) begin
      m.valid = 1'b0; m.we = 1'b0; m_lvl = 0;
    end else begin
      m.valid = 1'b1;
      m.pc    = pc;
      m.op    = d.op;
      m.sel   = d.sel;
      m.s1    = ref_src(d.en1, d.a1, d.imm1);
      m.s2    = ref_src(d.en2, d.a2, d.imm2);
      m.wa    = d.wa;
      m.we    = d.ok;
      m.err   = !d.ok;
      m_lvl   = d.ok ? 2 : 1;
    end

    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(m.valid));
    check("wr_en", 64'(wr_en), 64'(m.we));
    if (m_lvl >= 1) begin
      check("out_pc", 64'(out_pc), 64'(m.pc));
      check("alu_op", 64'(alu_op), 64'(m.op));
      check("alu_sel", 64'(alu_sel), 64'(m.sel));
      check("ins_err", 64'(ins_err), 64'(m.err));
    end
    if (m_lvl == 2) begin
      check("src_data1", 64'(src_data1), 64'(m.s1));
      check("src_data2", 64'(src_data2), 64'(m.s2));
      check("wr_addr", 64'(wr_addr), 64'(m.wa));
    end
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  task automatic quiet();
    ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_wr_data = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0;
    stall_in = 0; flush = 0; reset = 0;
  endtask

  task automatic rand_ins();
    int          k;
    logic [24:0] e;
    logic [4:0]  rs, rt, rd;
    k  = $urandom_range(0, 12);
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    if (k < 11) begin
      e = TBL[k];
      if (e[1:0] < 2'd2) ins = mk_i(e[24:19], rs, rt, 16'($urandom));
      else               ins = mk_r(rs, rt, rd, 5'($urandom), e[18:13]);
    end else if (k == 11) begin
      ins = $urandom;
    end else begin
      ins = mk_r(rs, rt, rd, 5'($urandom), 6'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEADBEEF;
    regs[6] = 32'h80000000;
    m = '0; m_lvl = 0;
    quiet();
    in_valid = 0; pc = 0; ins = 0;

    reset = 1; step(); step();
    reset = 0;

    // ORI r1,r0,0x1100
    in_valid = 1; pc = 32'h100; ins = mk_i(6'b001101, 5'd0, 5'd1, 16'h1100); step();
    // OR r3,r1,r2 with EX and MEM both writing r1
    pc = 32'h104; ins = mk_r(5'd1, 5'd2, 5'd3, 5'd0, 6'b100101);
    ex_wr_en = 1; ex_wr_addr = 5'd1; ex_wr_data = 32'hAAAA0000;
    mem_wr_en = 1; mem_wr_addr = 5'd1; mem_wr_data = 32'h5; step();
    // Load-use on r2 with ANDI r4,r2,0xFF, then load retires
    quiet();
    pc = 32'h108; ins = mk_i(6'b001100, 5'd2, 5'd4, 16'h00FF);
    ex_is_load = 1; ex_wr_en = 1; ex_wr_addr = 5'd2; ex_wr_data = 32'h1234; step();
    quiet(); step();
    // SRA r5,r6,4
    pc = 32'h10C; ins = mk_r(5'd0, 5'd6, 5'd5, 5'd4, 6'b000011); step();
    // Hold for three cycles while inputs change, then flush during hold
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin rand_ins(); pc = $urandom; step(); end
    flush = 1; step();
    quiet();
    // Unknown opcode, then reset mid-stream
    pc = 32'h110; ins = 32'hFC000000; step();
    ins = mk_i(6'b001101, 5'd3, 5'd7, 16'hBEEF); step();
    reset = 1; step();
    reset = 0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rand_ins();
      pc          = $urandom;
      in_valid    = ($urandom_range(0, 99) < 85);
      stall_in    = ($urandom_range(0, 99) < 15);
      flush       = ($urandom_range(0, 99) < 5);
      reset       = ($urandom_range(0, 99) < 2);
      ex_wr_en    = ($urandom_range(0, 99) < 60);
      ex_is_load  = ($urandom_range(0, 99) < 25);
      ex_wr_addr  = 5'($urandom_range(0, 7));
      ex_wr_data  = $urandom;
      mem_wr_en   = ($urandom_range(0, 99) < 60);
      mem_wr_addr = 5'($urandom_range(0, 7));
      mem_wr_data = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ins_decode_pipe.md
INS_DECODE_PIPE -- requirements
Module: ins_decode_pipe

Interface
REQ-001 SHALL have parameter DATA_W, 32, operand/PC width.
REQ-002 SHALL have parameter RF_AW, 5, register-address width.
REQ-003 SHALL have parameter ALUOP_W, 8, ALU operation code width.
REQ-004 SHALL have parameter FWD_EN, 1, 1 = EX/MEM forwarding enabled, 0 = register-file data only.
REQ-005 SHALL have clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have reset, input, 1, synchronous, active-high.
REQ-007 SHALL have in_valid, input, 1, pc/ins valid this cycle.
REQ-008 SHALL have pc, input, DATA_W, instruction address (carried through).
REQ-009 SHALL have ins, input, 32, MIPS instruction word.
REQ-010 SHALL have rd1_en/rd2_en, output, 1 each, register-file read enables (combinational).
REQ-011 SHALL have addr1/addr2, output, RF_AW each, register-file read addresses (combinational).
REQ-012 SHALL have rf_data1/rf_data2, input, DATA_W each, register-file read data.
REQ-013 SHALL have ex_wr_en, ex_wr_addr, ex_wr_data, ex_is_load: inputs, 1/RF_AW/DATA_W/1, EX-stage result.
REQ-014 SHALL have mem_wr_en, mem_wr_addr, mem_wr_data: inputs, 1/RF_AW/DATA_W, MEM-stage result.
REQ-015 SHALL have stall_in, input, 1, downstream hold; flush, input, 1, kill ID/EX contents.
REQ-016 SHALL have stall_req, output, 1, combinational load-use stall to fetch.
REQ-017 SHALL have registered outputs out_valid (1), out_pc (DATA_W), alu_op (ALUOP_W), alu_sel (3), src_data1/src_data2 (DATA_W), wr_addr (RF_AW), wr_en (1), ins_err (1).

Function
REQ-018 SHALL decode: ORI 001101 op 0x25 sel 001 zero-ext imm; ANDI 001100 op 0x24 sel 001; XORI 001110 op 0x26 sel 001; LUI 001111 op 0x25 sel 001, src1=0, imm={imm16,16'b0}; I-type wr_addr=rt, rd1_en=1 (LUI 0), rd2_en=0.
REQ-019 SHALL decode opcode 000000: funct 100101/100100/100110/100111 -> op 0x25/0x24/0x26/0x27 sel 001; 000000/000010/000011 -> op 0x7C/0x02/0x03 sel 010, src1=zero-ext shamt, src2=rt; R-type wr_addr=rd.
REQ-020 SHALL treat any other opcode/funct as NOP with wr_en=0, alu_op=0, alu_sel=0 and ins_err=1.
REQ-021 SHALL select each source as: disabled read -> immediate/shamt; else ex match -> ex_wr_data; else mem match -> mem_wr_data; else rf data.
REQ-022 A match SHALL require FWD_EN=1, wr_en=1, equal address, and address nonzero; address 0 SHALL read as 0.
REQ-023 stall_req SHALL be 1 when in_valid, ex_is_load, ex_wr_en, ex_wr_addr nonzero and equal to an enabled read address.
REQ-024 When stall_req=1 and stall_in=0, ID/EX SHALL load a bubble (out_valid=0, wr_en=0).
REQ-025 When stall_in=1, ID/EX SHALL hold all contents; stall_req still evaluated.
REQ-026 flush SHALL clear out_valid and wr_en next edge, overriding stall_in and stall_req.
REQ-027 Otherwise ID/EX SHALL capture decoded result; out_valid=in_valid; latency exactly 1 cycle.
REQ-028 in_valid=0 SHALL load a bubble, stall_req=0.

Reset
REQ-029 reset SHALL force, next edge, every registered output to 0; it overrides flush and stall_in.
REQ-030 During reset, rd1_en, rd2_en, addr1, addr2 and stall_req SHALL be 0.

Structure
REQ-031 Opcode/funct values, ALU op codes and alu_sel codes SHALL live in shared package mips_defs_pkg.
REQ-032 Decode SHALL be sub-module ins_decode_ctrl (combinational); forwarding, hazard logic and ID/EX register SHALL be in ins_decode_pipe.

Verification
REQ-033 ORI r1,r0,0x1100 then edge -> out_valid=1, alu_op=0x25, src1=0, src2=0x00001100, wr_addr=1, wr_en=1.
REQ-034 OR r3,r1,r2 with ex writing r1=0xAAAA0000, mem writing r1=0x5 -> src1=0xAAAA0000.
REQ-035 ex_is_load on r2, ANDI r4,r2,0xFF -> stall_req=1, next out_valid=0; load cleared -> instruction issues.
REQ-036 SRA r5,r6,4 with rf r6=0x80000000 -> alu_sel=010, src1=4, src2=0x80000000.
REQ-037 stall_in=1 for 3 cycles -> outputs unchanged; flush with stall_in=1 -> out_valid=0.
REQ-038 Opcode 111111 -> ins_err=1, wr_en=0; reset mid-stream -> all outputs 0 next edge.
